// File: rtl/pipe_stage_elastic.sv
// Two-entry elastic pipeline stage (main + skid) for the EX/MEM payload.
// Handshake flags and occupancy come straight from registers, so there is no combinational ready/valid path.
module pipe_stage_elastic #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              async_reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_pc4,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_wdata,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_pc4,

    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wdata;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] pc4;
    } payload_t;

    state_t   state;
    state_t   state_n;
    payload_t main_q;
    payload_t main_n;
    payload_t skid_q;
    payload_t skid_n;
    payload_t in_payload;
    logic     push;
    logic     pop;
    logic     stall_hit;

    always_comb begin
        in_payload = '{ctrl: in_ctrl, alu: in_alu, wdata: in_wdata, rd: in_rd, pc4: in_pc4};
        push       = in_valid & in_ready;
        pop        = out_valid & out_ready;
        stall_hit  = out_valid & ~out_ready;
    end

    // Entries are zeroed whenever they empty, so main_q can drive out_* without an output mask.
    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
            main_n  = '0;
            skid_n  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_n  = in_payload;
                        state_n = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_n = in_payload;
                    end else if (push) begin
                        skid_n  = in_payload;
                        state_n = FULL;
                    end else if (pop) begin
                        main_n  = '0;
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_n  = skid_q;
                        skid_n  = '0;
                        state_n = ONE;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    main_n  = '0;
                    skid_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_n;
            main_q    <= main_n;
            skid_q    <= skid_n;
            out_valid <= (state_n != EMPTY);
            in_ready  <= (state_n != FULL);
        end
    end

    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (stall_hit && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        occupancy = state;
        out_ctrl  = main_q.ctrl;
        out_alu   = main_q.alu;
        out_wdata = main_q.wdata;
        out_rd    = main_q.rd;
        out_pc4   = main_q.pc4;
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: a vector table plus hand-written flush, saturation and reset sequences.
module tb_pipe_stage_elastic;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int CNT_W  = 4;

    logic              clock;
    logic              async_reset;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_wdata;
    logic [RD_W-1:0]   in_rd;
    logic [DATA_W-1:0] in_pc4;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_alu;
    logic [DATA_W-1:0] out_wdata;
    logic [RD_W-1:0]   out_rd;
    logic [DATA_W-1:0] out_pc4;
    logic              flush;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;
    logic              stall_clr;

    pipe_stage_elastic #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .RD_W  (RD_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock      (clock),
        .async_reset(async_reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_alu     (in_alu),
        .in_wdata   (in_wdata),
        .in_rd      (in_rd),
        .in_pc4     (in_pc4),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_alu    (out_alu),
        .out_wdata  (out_wdata),
        .out_rd     (out_rd),
        .out_pc4    (out_pc4),
        .flush      (flush),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt),
        .stall_clr  (stall_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic        clr;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        ev;
        logic        eir;
        logic [1:0]  eocc;
        logic [31:0] ealu;
        logic [4:0]  erd;
        logic [3:0]  estall;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl, input logic clr,
                                input logic [31:0] alu, input logic [4:0] rd,
                                input logic ev, input logic eir, input logic [1:0] eocc,
                                input logic [31:0] ealu, input logic [4:0] erd, input logic [3:0] estall);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.clr = clr; v.alu = alu; v.rd = rd;
        v.ev = ev; v.eir = eir; v.eocc = eocc; v.ealu = ealu; v.erd = erd; v.estall = estall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Side fields are tied to alu so one table column determines the whole payload.
    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic clr,
                         input logic [31:0] alu, input logic [4:0] rd);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        stall_clr = clr;
        in_alu    = alu;
        in_rd     = rd;
        in_ctrl   = alu[7:0] ^ 8'hA5;
        in_wdata  = ~alu;
        in_pc4    = alu + 32'd4;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic eir, input logic [1:0] eocc,
                             input logic [31:0] ealu, input logic [4:0] erd, input logic [3:0] estall);
        logic [7:0]  ectrl;
        logic [31:0] ewdata;
        logic [31:0] epc4;
        ectrl  = ev ? (ealu[7:0] ^ 8'hA5) : 8'h00;
        ewdata = ev ? ~ealu : 32'h0;
        epc4   = ev ? (ealu + 32'd4) : 32'h0;
        chk({tag, " out_valid"}, 64'(out_valid), 64'(ev));
        chk({tag, " in_ready"},  64'(in_ready),  64'(eir));
        chk({tag, " occupancy"}, 64'(occupancy), 64'(eocc));
        chk({tag, " out_alu"},   64'(out_alu),   64'(ealu));
        chk({tag, " out_rd"},    64'(out_rd),    64'(erd));
        chk({tag, " out_ctrl"},  64'(out_ctrl),  64'(ectrl));
        chk({tag, " out_wdata"}, 64'(out_wdata), 64'(ewdata));
        chk({tag, " out_pc4"},   64'(out_pc4),   64'(epc4));
        chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'(estall));
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 5'd3);
        async_reset = 1'b1;
        #2;
        check_all("reset", 1'b0, 1'b1, 2'd0, 32'h0, 5'd0, 4'd0);
        #5;
        async_reset = 1'b0;

        // single beat
        vecs.push_back(mk(1,1,0,0, 32'h0000_1234, 5'd5,  1,1,2'd1, 32'h0000_1234, 5'd5, 4'd0));
        vecs.push_back(mk(0,1,0,0, 32'h0,         5'd0,  0,1,2'd0, 32'h0,         5'd0, 4'd0));
        // back-pressure into FULL, then drain in order
        vecs.push_back(mk(1,0,0,0, 32'h11, 5'd1,  1,1,2'd1, 32'h11, 5'd1, 4'd0));
        vecs.push_back(mk(1,0,0,0, 32'h22, 5'd2,  1,0,2'd2, 32'h11, 5'd1, 4'd1));
        vecs.push_back(mk(1,0,0,0, 32'h33, 5'd3,  1,0,2'd2, 32'h11, 5'd1, 4'd2));
        vecs.push_back(mk(0,1,0,0, 32'h0,  5'd0,  1,1,2'd1, 32'h22, 5'd2, 4'd2));
        vecs.push_back(mk(0,1,0,0, 32'h0,  5'd0,  0,1,2'd0, 32'h0,  5'd0, 4'd2));
        vecs.push_back(mk(0,1,0,1, 32'h0,  5'd0,  0,1,2'd0, 32'h0,  5'd0, 4'd0));
        // streaming 1..8
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(1,1,0,0, 32'(k), 5'(k),  1,1,2'd1, 32'(k), 5'(k), 4'd0));
        vecs.push_back(mk(0,1,0,0, 32'h0,  5'd0,  0,1,2'd0, 32'h0,  5'd0, 4'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].clr, vecs[i].alu, vecs[i].rd);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eir, vecs[i].eocc,
                      vecs[i].ealu, vecs[i].erd, vecs[i].estall);
        end

        // flush in FULL with a simultaneous offer; stall_cnt still counts that cycle
        drive(1, 0, 0, 0, 32'hA1, 5'd10); step();
        check_all("fl_a", 1, 1, 2'd1, 32'hA1, 5'd10, 4'd0);
        drive(1, 0, 0, 0, 32'hA2, 5'd11); step();
        check_all("fl_b", 1, 0, 2'd2, 32'hA1, 5'd10, 4'd1);
        drive(1, 0, 1, 0, 32'h99, 5'd9);  step();
        check_all("fl_kill", 0, 1, 2'd0, 32'h0, 5'd0, 4'd2);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 32'h0, 5'd0); step();
            check_all($sformatf("fl_after%0d", i), 0, 1, 2'd0, 32'h0, 5'd0, 4'd2);
        end

        // saturation with one held beat
        drive(1, 0, 0, 1, 32'h55, 5'd4); step();
        check_all("sat_load", 1, 1, 2'd1, 32'h55, 5'd4, 4'd0);
        drive(0, 0, 0, 0, 32'h0, 5'd0);
        for (int i = 0; i < 20; i++) step();
        check_all("sat_15", 1, 1, 2'd1, 32'h55, 5'd4, 4'd15);
        drive(0, 0, 0, 1, 32'h0, 5'd0); step();
        check_all("sat_clr", 1, 1, 2'd1, 32'h55, 5'd4, 4'd0);
        drive(0, 0, 0, 0, 32'h0, 5'd0); step();
        check_all("sat_recount", 1, 1, 2'd1, 32'h55, 5'd4, 4'd1);
        drive(1, 0, 0, 0, 32'hB2, 5'd6); step();
        check_all("pre_rst_full", 1, 0, 2'd2, 32'h55, 5'd4, 4'd2);

        // asynchronous reset between edges while FULL
        drive(0, 0, 0, 0, 32'h0, 5'd0);
        #2;
        async_reset = 1'b1;
        #1;
        check_all("async_rst", 0, 1, 2'd0, 32'h0, 5'd0, 4'd0);
        async_reset = 1'b0;
        drive(1, 1, 0, 0, 32'h77, 5'd7); step();
        check_all("post_rst_push", 1, 1, 2'd1, 32'h77, 5'd7, 4'd0);
        drive(0, 1, 0, 0, 32'h0, 5'd0); step();
        check_all("post_rst_drain", 0, 1, 2'd0, 32'h0, 5'd0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
